// File: rtl/simple_ram.sv
// Simple dual-port RAM: one write port, one registered read port (latency 1), read-first on collisions.
// No flow control; rst clears only the read-data register so the array still maps onto block RAM.
module simple_ram #(
  parameter int width   = 8,
  parameter int widthad = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [widthad-1:0] wraddress,
  input  logic               wren,
  input  logic [width-1:0]   data,
  input  logic [widthad-1:0] rdaddress,
  output logic [width-1:0]   q
);

  localparam int depth = 2 ** widthad;

  logic [width-1:0] mem [0:depth-1];
  logic [width-1:0] q_d;
  logic [width-1:0] q_q;

  // The old word is sampled before the same-edge write lands, giving read-first behaviour.
  always_comb begin
    q_d = mem[rdaddress];
    if (rst) begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wren) begin
      mem[wraddress] <= data;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: tb/tb_simple_ram.sv
// Bench for simple_ram: two instances (8x16 and 11x16384) checked every cycle against an array model,
// plus directed literal expectations taken from the hand-worked test plan.
module tb_simple_ram;

  logic        clk;
  int          checks;
  int          errors;

  // Instance 0: width=8, widthad=4
  logic        rst0;
  logic [3:0]  wa0;
  logic        we0;
  logic [7:0]  d0;
  logic [3:0]  ra0;
  logic [7:0]  q0;

  // Instance 1: width=11, widthad=14
  logic        rst1;
  logic [13:0] wa1;
  logic        we1;
  logic [10:0] d1;
  logic [13:0] ra1;
  logic [10:0] q1;

  logic [7:0]  model0 [0:15];
  logic [10:0] model1 [0:16383];
  logic [7:0]  exp0;
  logic [10:0] exp1;
  bit          vld;

  simple_ram #(.width(8), .widthad(4)) dut0 (
    .clk(clk), .rst(rst0), .wraddress(wa0), .wren(we0), .data(d0), .rdaddress(ra0), .q(q0)
  );

  simple_ram #(.width(11), .widthad(14)) dut1 (
    .clk(clk), .rst(rst1), .wraddress(wa1), .wren(we1), .data(d1), .rdaddress(ra1), .q(q1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each edge the read port returns what the array held before this edge's write (0 under reset).
  always @(posedge clk) begin
    exp0 = rst0 ? 8'h00 : model0[ra0];
    exp1 = rst1 ? 11'h000 : model1[ra1];
    if (we0) model0[wa0] = d0;
    if (we1) model1[wa1] = d1;
    vld = 1'b1;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (vld) begin
      check("q0_model", {8'h00, q0}, {8'h00, exp0});
      check("q1_model", {5'h00, q1}, {5'h00, exp1});
    end
  end

  task automatic step0(input logic r, input logic we, input logic [3:0] wa,
                       input logic [7:0] d, input logic [3:0] ra);
    rst0 = r; we0 = we; wa0 = wa; d0 = d; ra0 = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic we, input logic [13:0] wa,
                       input logic [10:0] d, input logic [13:0] ra);
    rst1 = 1'b0; we1 = we; wa1 = wa; d1 = d; ra1 = ra;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vld    = 1'b0;
    rst0 = 1'b1; we0 = 1'b0; wa0 = '0; d0 = '0; ra0 = '0;
    rst1 = 1'b1; we1 = 1'b0; wa1 = '0; d1 = '0; ra1 = '0;

    // Power-up contents are zero; instance 1 also gets a parent-style preload.
    for (int i = 0; i < 16; i++) begin
      dut0.mem[i] = 8'h00;
      model0[i]   = 8'h00;
    end
    for (int i = 0; i < 16384; i++) begin
      dut1.mem[i] = 11'h000;
      model1[i]   = 11'h000;
    end
    dut1.mem[100] = 11'h155;
    model1[100]   = 11'h155;

    step0(1'b1, 1'b0, 4'd0, 8'h00, 4'd0);
    step0(1'b1, 1'b0, 4'd0, 8'h00, 4'd0);
    check("reset_q", {8'h00, q0}, 16'h0000);

    for (int i = 0; i < 16; i++) begin
      step0(1'b0, 1'b0, 4'd0, 8'h00, 4'(i));
      check("init_read", {8'h00, q0}, 16'h0000);
    end

    // Write then read: data appears one edge after the address is presented.
    step0(1'b0, 1'b1, 4'd3, 8'hA5, 4'd3);
    check("lat_same_edge", {8'h00, q0}, 16'h0000);
    step0(1'b0, 1'b0, 4'd0, 8'h00, 4'd3);
    check("lat_next_edge", {8'h00, q0}, 16'h00A5);

    // Read-during-write at the same address returns the old word.
    step0(1'b0, 1'b1, 4'd7, 8'h11, 4'd0);
    step0(1'b0, 1'b1, 4'd7, 8'h22, 4'd7);
    check("rdw_old", {8'h00, q0}, 16'h0011);
    step0(1'b0, 1'b0, 4'd0, 8'h00, 4'd7);
    check("rdw_new", {8'h00, q0}, 16'h0022);

    // wren=0 must not disturb memory.
    step0(1'b0, 1'b0, 4'd0, 8'hFF, 4'd0);
    step0(1'b0, 1'b0, 4'd0, 8'h00, 4'd0);
    check("wren_off", {8'h00, q0}, 16'h0000);

    step0(1'b0, 1'b1, 4'd15, 8'h3C, 4'd0);
    step0(1'b0, 1'b1, 4'd0,  8'hC3, 4'd15);
    check("bound_hi", {8'h00, q0}, 16'h003C);
    step0(1'b0, 1'b0, 4'd0,  8'h00, 4'd0);
    check("bound_lo", {8'h00, q0}, 16'h00C3);
    step0(1'b0, 1'b0, 4'd0,  8'h00, 4'd15);
    check("pre_rst_q", {8'h00, q0}, 16'h003C);

    // Reset mid-stream discards the read but still commits the write.
    step0(1'b1, 1'b1, 4'd5, 8'h77, 4'd15);
    check("mid_rst_q", {8'h00, q0}, 16'h0000);
    step0(1'b0, 1'b0, 4'd0, 8'h00, 4'd5);
    check("rst_write", {8'h00, q0}, 16'h0077);
    step0(1'b0, 1'b0, 4'd0, 8'h00, 4'd15);
    check("rst_keep", {8'h00, q0}, 16'h003C);

    // Mixed traffic on the small instance, checked by the model alone.
    for (int i = 0; i < 60; i++) begin
      step0(($urandom_range(0, 15) == 0), 1'($urandom), 4'($urandom), 8'($urandom), 4'($urandom));
    end
    step0(1'b0, 1'b0, 4'd0, 8'h00, 4'd0);

    // Wide/deep instance: extremes of data and address.
    step1(1'b1, 14'd16383, 11'h7FF, 14'd0);
    check("w11_rst_rel", {5'h00, q1}, 16'h0000);
    step1(1'b1, 14'd0, 11'h001, 14'd16383);
    check("w11_top", {5'h00, q1}, 16'h07FF);
    step1(1'b0, 14'd0, 11'h000, 14'd0);
    check("w11_zero", {5'h00, q1}, 16'h0001);
    step1(1'b0, 14'd0, 11'h000, 14'd100);
    check("w11_preload", {5'h00, q1}, 16'h0155);

    for (int i = 0; i < 40; i++) begin
      step1(1'($urandom), 14'($urandom_range(0, 31)), 11'($urandom), 14'($urandom_range(0, 31)));
    end
    step1(1'b0, 14'd0, 11'h000, 14'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
